// File: rtl/mem_data_access.sv
// rtl/mem_data_access.sv - MEM-stage data-memory access unit (load/store FSM, alignment, writeback mux)
// Optional misalignment checking is enabled with `define MEM_ADDR_CHECK_EN.
module mem_data_access #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  stall_current_stage,
  input  logic                  mem_en_in,
  input  logic                  mem_write_in,
  input  logic [1:0]            mem_size_in,
  input  logic                  mem_sign_ext_in,
  input  logic [DATA_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] write_data_in,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic                  write_reg_en_in,
  input  logic [4:0]            write_reg_addr_in,
  input  logic [DATA_WIDTH-1:0] debug_pc_addr_in,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  write_reg_en_out,
  output logic [4:0]            write_reg_addr_out,
  output logic [DATA_WIDTH-1:0] debug_pc_addr_out,
  output logic                  stall_request,
  output logic                  addr_err_out,
  output logic                  dbus_req,
  output logic                  dbus_wr,
  output logic [1:0]            dbus_size,
  output logic [DATA_WIDTH-1:0] dbus_addr,
  output logic [DATA_WIDTH-1:0] dbus_wdata,
  output logic [3:0]            dbus_wstrb,
  input  logic                  dbus_addr_ok,
  input  logic                  dbus_data_ok,
  input  logic [DATA_WIDTH-1:0] dbus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state, next_state;
  logic            discard, discard_next;
  logic [1:0]      lat_lo, lat_size;
  logic            lat_sign, lat_wr;
  logic [31:0]     load_buf;

  logic [1:0]      size_norm;
  logic [1:0]      addr_lo;
  logic            valid_access;
  logic [31:0]     shifted, load_aligned;

  assign size_norm = (mem_size_in == 2'd3) ? 2'd2 : mem_size_in;

`ifdef MEM_ADDR_CHECK_EN
  logic misaligned;
  assign misaligned   = ((size_norm == 2'd1) && addr_in[0]) ||
                        ((size_norm == 2'd2) && (addr_in[1:0] != 2'b00));
  assign addr_err_out = (state == IDLE) && mem_en_in && misaligned;
  assign addr_lo      = addr_in[1:0];
`else
  assign addr_err_out = 1'b0;
  // Without checking, silently round the address down to the access size.
  assign addr_lo      = (size_norm == 2'd2) ? 2'b00 :
                        (size_norm == 2'd1) ? {addr_in[1], 1'b0} : addr_in[1:0];
`endif

  assign valid_access = (state == IDLE) && mem_en_in && !flush && !addr_err_out;

  assign shifted = dbus_rdata >> {lat_lo, 3'b000};
  always_comb begin
    load_aligned = dbus_rdata;
    case (lat_size)
      2'd0:    load_aligned = {{24{lat_sign & shifted[7]}}, shifted[7:0]};
      2'd1:    load_aligned = {{16{lat_sign & shifted[15]}}, shifted[15:0]};
      default: load_aligned = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      discard  <= 1'b0;
      lat_lo   <= 2'b00;
      lat_size <= 2'd0;
      lat_sign <= 1'b0;
      lat_wr   <= 1'b0;
      load_buf <= 32'h0;
    end else begin
      state   <= next_state;
      discard <= discard_next;
      if (valid_access) begin
        lat_lo   <= addr_lo;
        lat_size <= size_norm;
        lat_sign <= mem_sign_ext_in;
        lat_wr   <= mem_write_in;
      end
      if (state == WAIT && dbus_data_ok && !discard && !flush)
        load_buf <= load_aligned;
    end
  end

  always_comb begin
    next_state    = state;
    discard_next  = discard;
    stall_request = 1'b0;
    dbus_req      = 1'b0;
    case (state)
      IDLE: begin
        discard_next = 1'b0;
        if (valid_access) begin
          stall_request = 1'b1;
          next_state    = REQ;
        end
      end
      REQ: begin
        stall_request = 1'b1;
        dbus_req      = 1'b1;
        if (dbus_addr_ok) begin
          next_state = WAIT;
          if (flush) discard_next = 1'b1;
        end else if (flush) begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        stall_request = 1'b1;
        if (flush) discard_next = 1'b1;
        if (dbus_data_ok) begin
          discard_next = 1'b0;
          next_state   = (discard || flush) ? IDLE : DONE;
        end
      end
      DONE: begin
        if (flush || !stall_current_stage) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Address/data come from the held EX/MEM inputs; the stall keeps them stable.
  assign dbus_wr   = lat_wr;
  assign dbus_size = lat_size;
  assign dbus_addr = {addr_in[31:2], lat_lo};

  always_comb begin
    dbus_wstrb = 4'b0000;
    dbus_wdata = write_data_in;
    case (lat_size)
      2'd0: begin
        dbus_wdata = {4{write_data_in[7:0]}};
        if (lat_wr) dbus_wstrb = 4'b0001 << lat_lo;
      end
      2'd1: begin
        dbus_wdata = {2{write_data_in[15:0]}};
        if (lat_wr) dbus_wstrb = lat_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        dbus_wdata = write_data_in;
        if (lat_wr) dbus_wstrb = 4'b1111;
      end
    endcase
  end

  assign result_out         = (state == DONE && !lat_wr) ? load_buf : result_in;
  assign write_reg_en_out   = write_reg_en_in & ~flush & ~addr_err_out;
  assign write_reg_addr_out = write_reg_addr_in;
  assign debug_pc_addr_out  = debug_pc_addr_in;

endmodule
